// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step sequencer for the PCPU pipeline: produces the pipeline
// clock enable from the debug switch, the step button and a PC breakpoint.
module cpu_run_ctrl #(
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 16,
    parameter int CYC_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 debug_en,
    input  logic                 btn_step,
    input  logic [CNT_WIDTH-1:0] step_count,
    input  logic                 bp_en,
    input  logic [PC_WIDTH-1:0]  bp_addr,
    input  logic [PC_WIDTH-1:0]  pc,
    output logic                 cpu_en,
    output logic                 halted,
    output logic                 bp_halt,
    output logic [1:0]           state,
    output logic [CYC_WIDTH-1:0] cycle_cnt
);

    typedef enum logic [1:0] {
        S_HALT     = 2'd0,
        S_RUN      = 2'd1,
        S_STEP     = 2'd2,
        S_WAIT_REL = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CYC_WIDTH-1:0] CYC_ONE = CYC_WIDTH'(1);

    state_t                state_q;
    state_t                state_d;
    logic [CNT_WIDTH-1:0]  remaining_q;
    logic [CNT_WIDTH-1:0]  remaining_d;
    logic                  resume_q;
    logic                  resume_d;
    logic                  bp_halt_q;
    logic                  bp_halt_d;
    logic                  halted_q;
    logic                  btn_q;
    logic [CYC_WIDTH-1:0]  cycle_cnt_q;
    logic                  step_edge;
    logic                  bp_hit;

    assign step_edge = btn_step & ~btn_q;
    // resume masks the breakpoint until the first enabled cycle after leaving
    // HALT, so a resumed run always executes the instruction at bp_addr.
    assign bp_hit    = bp_en & (pc == bp_addr) & ~resume_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_HALT;
            halted_q    <= 1'b1;
            bp_halt_q   <= 1'b0;
            remaining_q <= '0;
            resume_q    <= 1'b0;
            btn_q       <= 1'b1;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            halted_q    <= (state_d == S_HALT);
            bp_halt_q   <= bp_halt_d;
            remaining_q <= remaining_d;
            resume_q    <= resume_d;
            btn_q       <= btn_step;
            if (cpu_en) begin
                cycle_cnt_q <= cycle_cnt_q + CYC_ONE;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        bp_halt_d   = bp_halt_q;
        remaining_d = remaining_q;
        resume_d    = resume_q & ~cpu_en;
        case (state_q)
            S_HALT: begin
                if (debug_en && step_edge) begin
                    state_d     = S_STEP;
                    remaining_d = (step_count == '0) ? CNT_ONE : step_count;
                    resume_d    = 1'b1;
                end else if (!debug_en && (!bp_halt_q || step_edge)) begin
                    state_d   = S_RUN;
                    bp_halt_d = 1'b0;
                    resume_d  = 1'b1;
                end
            end
            S_RUN: begin
                if (bp_hit) begin
                    state_d   = S_HALT;
                    bp_halt_d = 1'b1;
                end else if (debug_en) begin
                    state_d   = S_HALT;
                    bp_halt_d = 1'b0;
                end
            end
            S_STEP: begin
                remaining_d = remaining_q - CNT_ONE;
                if (remaining_q == CNT_ONE) begin
                    state_d = S_WAIT_REL;
                end
            end
            S_WAIT_REL: begin
                if (!btn_step) begin
                    state_d   = S_HALT;
                    bp_halt_d = 1'b0;
                end
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    // Output logic
    always_comb begin
        cpu_en = 1'b0;
        if (!rst) begin
            case (state_q)
                S_RUN:   cpu_en = ~bp_hit;
                S_STEP:  cpu_en = 1'b1;
                default: cpu_en = 1'b0;
            endcase
        end
    end

    assign halted    = halted_q;
    assign bp_halt   = bp_halt_q;
    assign state     = state_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios plus a randomized run checked
// against a cycle-level behavioural model; a 4-bit-counter twin checks wrap.
module tb_cpu_run_ctrl;

    localparam int M_HALT = 0;
    localparam int M_RUN  = 1;
    localparam int M_STEP = 2;
    localparam int M_WAIT = 3;

    logic        clk;
    logic        rst;
    logic        debug_en;
    logic        btn_step;
    logic [15:0] step_count;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc;
    logic        cpu_en;
    logic        halted;
    logic        bp_halt;
    logic [1:0]  state;
    logic [31:0] cycle_cnt;
    logic        en4;
    logic        halted4;
    logic        bp_halt4;
    logic [1:0]  state4;
    logic [3:0]  cnt4;

    int errors = 0;
    int checks = 0;

    // Model state
    int          m_mode    = M_HALT;
    int          m_rem     = 0;
    logic        m_resume  = 1'b0;
    logic        m_bp_halt = 1'b0;
    logic        m_halted  = 1'b1;
    logic        m_btn_q   = 1'b1;
    logic [31:0] m_cnt     = '0;

    // Per-cycle expected and observed samples
    logic        e_en, o_en;
    logic [1:0]  e_state, o_state;
    logic        e_halted, o_halted;
    logic        e_bp_halt, o_bp_halt;
    logic [31:0] e_cnt, o_cnt;
    logic [3:0]  o_cnt4;
    logic [4:0]  o_misc4;

    cpu_run_ctrl dut (
        .clk(clk), .rst(rst), .debug_en(debug_en), .btn_step(btn_step),
        .step_count(step_count), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
        .cpu_en(cpu_en), .halted(halted), .bp_halt(bp_halt), .state(state),
        .cycle_cnt(cycle_cnt)
    );

    cpu_run_ctrl #(.CYC_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .debug_en(debug_en), .btn_step(btn_step),
        .step_count(step_count), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
        .cpu_en(en4), .halted(halted4), .bp_halt(bp_halt4), .state(state4),
        .cycle_cnt(cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic model_en();
        logic hit;
        if (rst) return 1'b0;
        hit = bp_en && (pc == bp_addr) && !m_resume;
        return (m_mode == M_RUN && !hit) || (m_mode == M_STEP);
    endfunction

    task automatic model_update(input logic en);
        logic hit;
        logic edge_v;
        if (rst) begin
            m_mode = M_HALT; m_rem = 0; m_resume = 1'b0; m_bp_halt = 1'b0;
            m_halted = 1'b1; m_btn_q = 1'b1; m_cnt = '0;
            return;
        end
        hit    = bp_en && (pc == bp_addr) && !m_resume;
        edge_v = btn_step && !m_btn_q;
        if (en) begin
            m_cnt    = m_cnt + 32'd1;
            m_resume = 1'b0;
        end
        case (m_mode)
            M_HALT: begin
                if (debug_en && edge_v) begin
                    m_mode   = M_STEP;
                    m_rem    = (int'(step_count) == 0) ? 1 : int'(step_count);
                    m_resume = 1'b1;
                end else if (!debug_en && (!m_bp_halt || edge_v)) begin
                    m_mode = M_RUN; m_bp_halt = 1'b0; m_resume = 1'b1;
                end
            end
            M_RUN: begin
                if (hit) begin
                    m_mode = M_HALT; m_bp_halt = 1'b1;
                end else if (debug_en) begin
                    m_mode = M_HALT; m_bp_halt = 1'b0;
                end
            end
            M_STEP: begin
                m_rem = m_rem - 1;
                if (m_rem == 0) m_mode = M_WAIT;
            end
            default: begin
                if (!btn_step) begin
                    m_mode = M_HALT; m_bp_halt = 1'b0;
                end
            end
        endcase
        m_btn_q  = btn_step;
        m_halted = (m_mode == M_HALT);
    endtask

    // One clock: sample DUT and model at the falling edge, then advance.
    task automatic tick();
        @(negedge clk);
        e_en      = model_en();
        e_state   = 2'(m_mode);
        e_halted  = m_halted;
        e_bp_halt = m_bp_halt;
        e_cnt     = m_cnt;
        o_en      = cpu_en;
        o_state   = state;
        o_halted  = halted;
        o_bp_halt = bp_halt;
        o_cnt     = cycle_cnt;
        o_cnt4    = cnt4;
        o_misc4   = {en4, halted4, bp_halt4, state4};
        model_update(e_en);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; debug_en = 1'b0; btn_step = 1'b0; bp_en = 1'b0;
        bp_addr = 32'h10; pc = 32'h0; step_count = 16'd1;
        tick();
        tick();
        checks++;
        if (o_en !== 1'b0) begin errors++; $display("FAIL reset_cpu_en: got %0b want 0", o_en); end
        checks++;
        if (o_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", o_state); end
        checks++;
        if (o_halted !== 1'b1 || o_bp_halt !== 1'b0) begin
            errors++; $display("FAIL reset_flags: halted=%0b bp_halt=%0b want 1/0", o_halted, o_bp_halt);
        end
        checks++;
        if (o_cnt !== 32'd0) begin errors++; $display("FAIL reset_cycle_cnt: got %0d want 0", o_cnt); end
    endtask

    task automatic test_free_run();
        int bad = 0;
        rst = 1'b0; debug_en = 1'b0; bp_en = 1'b0;
        tick();
        checks++;
        if (o_state !== 2'd0 || o_en !== 1'b0) begin
            errors++; $display("FAIL free_first_cycle: state=%0d en=%0b want 0/0", o_state, o_en);
        end
        for (int i = 0; i < 100; i++) begin
            pc = {$urandom_range(0, 255), 2'b00};
            tick();
            if (o_en !== 1'b1 || o_state !== 2'd1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL free_run_en: %0d cycles not RUN/en, want 0", bad); end
        tick();
        checks++;
        if (o_cnt !== 32'd100) begin errors++; $display("FAIL free_cycle_cnt: got %0d want 100", o_cnt); end
        checks++;
        if (o_cnt4 !== 4'd4) begin errors++; $display("FAIL free_cnt_wrap4: got %0d want 4", o_cnt4); end
    endtask

    task automatic test_mode_switch();
        debug_en = 1'b1;
        tick();
        checks++;
        if (o_en !== 1'b1 || o_state !== 2'd1) begin
            errors++; $display("FAIL mode_last_cycle: en=%0b state=%0d want 1/1", o_en, o_state);
        end
        tick();
        checks++;
        if (o_state !== 2'd0 || o_halted !== 1'b1 || o_bp_halt !== 1'b0 || o_en !== 1'b0) begin
            errors++;
            $display("FAIL mode_halt: state=%0d halted=%0b bp_halt=%0b en=%0b want 0/1/0/0",
                     o_state, o_halted, o_bp_halt, o_en);
        end
    endtask

    task automatic test_step_burst(input logic [15:0] sc, input int want_n);
        int n = 0;
        debug_en = 1'b1; step_count = sc;
        for (int i = 0; i < 10; i++) begin
            btn_step = 1'b1;
            tick();
            if (i == 1) step_count = 16'd7;  // must not affect the running burst
            if (o_en === 1'b1) n++;
        end
        checks++;
        if (o_state !== 2'd3) begin errors++; $display("FAIL step_wait_rel sc=%0d: state=%0d want 3", sc, o_state); end
        btn_step = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (o_en === 1'b1) n++;
        end
        checks++;
        if (n != want_n) begin errors++; $display("FAIL step_burst_len sc=%0d: got %0d want %0d", sc, n, want_n); end
        checks++;
        if (o_state !== 2'd0 || o_halted !== 1'b1) begin
            errors++; $display("FAIL step_back_halt sc=%0d: state=%0d halted=%0b", sc, o_state, o_halted);
        end
        checks++;
        if (o_cnt !== e_cnt) begin errors++; $display("FAIL step_cycle_cnt sc=%0d: got %0d want %0d", sc, o_cnt, e_cnt); end
    endtask

    task automatic test_breakpoint();
        debug_en = 1'b0; bp_en = 1'b1; bp_addr = 32'h10; pc = 32'h0C;
        tick();
        tick();
        checks++;
        if (o_en !== 1'b1 || o_state !== 2'd1) begin
            errors++; $display("FAIL bp_pre_run: en=%0b state=%0d want 1/1", o_en, o_state);
        end
        pc = 32'h10;
        tick();
        checks++;
        if (o_en !== 1'b0) begin errors++; $display("FAIL bp_hit_en: got %0b want 0", o_en); end
        tick();
        checks++;
        if (o_state !== 2'd0 || o_halted !== 1'b1 || o_bp_halt !== 1'b1) begin
            errors++; $display("FAIL bp_halted: state=%0d halted=%0b bp_halt=%0b want 0/1/1",
                               o_state, o_halted, o_bp_halt);
        end
        tick();
        tick();
        checks++;
        if (o_state !== 2'd0 || o_en !== 1'b0) begin
            errors++; $display("FAIL bp_stays_halted: state=%0d en=%0b want 0/0", o_state, o_en);
        end
        btn_step = 1'b1;
        tick();
        btn_step = 1'b0;
        tick();
        checks++;
        if (o_state !== 2'd1 || o_en !== 1'b1 || o_bp_halt !== 1'b0) begin
            errors++; $display("FAIL bp_resume: state=%0d en=%0b bp_halt=%0b want 1/1/0",
                               o_state, o_en, o_bp_halt);
        end
        pc = 32'h14;
        tick();
        checks++;
        if (o_en !== 1'b1) begin errors++; $display("FAIL bp_after_resume: en=%0b want 1", o_en); end
        // breakpoint and debug_en rising together: breakpoint wins
        pc = 32'h10; debug_en = 1'b1;
        tick();
        checks++;
        if (o_en !== 1'b0) begin errors++; $display("FAIL bp_dbg_same_en: got %0b want 0", o_en); end
        tick();
        checks++;
        if (o_state !== 2'd0 || o_bp_halt !== 1'b1) begin
            errors++; $display("FAIL bp_dbg_same_halt: state=%0d bp_halt=%0b want 0/1", o_state, o_bp_halt);
        end
        bp_en = 1'b0;
    endtask

    task automatic test_btn_held_reset();
        int bad = 0;
        btn_step = 1'b1; debug_en = 1'b1; step_count = 16'd5; rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (o_state !== 2'd0 || o_en !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL held_btn_no_step: %0d bad cycles want 0", bad); end
        btn_step = 1'b0;
        tick();
        btn_step = 1'b1;
        tick();
        // first STEP cycle, remaining=5: reset lands mid-burst
        rst = 1'b1;
        tick();
        checks++;
        if (o_state !== 2'd2 || o_en !== 1'b0) begin
            errors++; $display("FAIL rst_mid_burst: state=%0d en=%0b want 2/0", o_state, o_en);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (o_state !== 2'd0 || o_en !== 1'b0 || o_cnt !== 32'd0) begin
            errors++; $display("FAIL rst_after_burst: state=%0d en=%0b cnt=%0d want 0/0/0",
                               o_state, o_en, o_cnt);
        end
        btn_step = 1'b0;
    endtask

    task automatic test_random();
        int bad_en = 0, bad_st = 0, bad_cnt = 0, bad_4 = 0;
        logic [31:0] pcs [3];
        pcs[0] = 32'h0C; pcs[1] = 32'h10; pcs[2] = 32'h14;
        bp_addr = 32'h10;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 39) == 0) debug_en = ~debug_en;
            if ($urandom_range(0, 5) == 0) btn_step = ~btn_step;
            if ($urandom_range(0, 19) == 0) bp_en = ~bp_en;
            step_count = 16'($urandom_range(0, 4));
            pc = pcs[$urandom_range(0, 2)];
            tick();
            if (o_en !== e_en) bad_en++;
            if (o_state !== e_state || o_halted !== e_halted || o_bp_halt !== e_bp_halt) bad_st++;
            if (o_cnt !== e_cnt) bad_cnt++;
            if (o_cnt4 !== e_cnt[3:0] || o_misc4 !== {e_en, e_halted, e_bp_halt, e_state}) bad_4++;
        end
        checks++;
        if (bad_en != 0) begin errors++; $display("FAIL rand_cpu_en: %0d cycles differ from model", bad_en); end
        checks++;
        if (bad_st != 0) begin errors++; $display("FAIL rand_state: %0d cycles differ from model", bad_st); end
        checks++;
        if (bad_cnt != 0) begin errors++; $display("FAIL rand_cycle_cnt: %0d cycles differ from model", bad_cnt); end
        checks++;
        if (bad_4 != 0) begin errors++; $display("FAIL rand_narrow_cnt: %0d cycles differ from model", bad_4); end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_mode_switch();
        test_step_burst(16'd3, 3);
        test_step_burst(16'd0, 1);
        test_breakpoint();
        test_btn_held_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
